// File: rtl/vga_pixel_scaler.sv
// 2x2 upscaler: pops source pixels from the pixel FIFO on even output lines, replays them from a line buffer on odd lines.
// Optional colour-bar test pattern is built only when VGA_SCALER_TESTPAT_EN is defined.
module vga_pixel_scaler #(
  parameter int unsigned IMG_WIDTH  = 320,
  parameter int unsigned IMG_HEIGHT = 240,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk_vga,
  input  logic                  rst,
`ifdef VGA_SCALER_TESTPAT_EN
  input  logic                  test_pattern,
`endif
  input  logic                  frame_start,
  input  logic                  video_on,
  input  logic [9:0]            vga_x,
  input  logic [9:0]            vga_y,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic [DATA_WIDTH-1:0] fifo_read_data,
  input  logic                  fifo_empty,
  output logic                  fifo_read_enable,
  output logic [3:0]            vga_r,
  output logic [3:0]            vga_g,
  output logic [3:0]            vga_b,
  output logic                  vga_hs,
  output logic                  vga_vs,
  output logic                  underrun,
  output logic [16:0]           pop_count
);

  localparam int unsigned AW    = $clog2(IMG_WIDTH);
  localparam logic [9:0]  X_END = 10'(2 * IMG_WIDTH);
  localparam logic [9:0]  Y_END = 10'(2 * IMG_HEIGHT);
  localparam logic [16:0] FULL  = 17'(IMG_WIDTH * IMG_HEIGHT);

  typedef enum logic [1:0] {IDLE, ACTIVE, STARVED} state_e;

  state_e                  state_q;
  logic [16:0]             pop_count_q;
  logic                    underrun_q;
  logic                    show1_q, odd1_q, xodd1_q, wr1_q;
  logic [AW-1:0]           addr1_q;
  logic                    hs1_q, vs1_q, hs2_q, vs2_q;
  logic [11:0]             rgb_q, rgb_d;
  logic [DATA_WIDTH-1:0]   hold_q, rd_q, pix;
  logic [DATA_WIDTH-1:0]   linebuf [IMG_WIDTH];
  logic                    in_area, run, due, pop, starve, tp_eff;
  logic                    unused_bits;

`ifdef VGA_SCALER_TESTPAT_EN
  localparam logic [9:0] BAR_W = 10'(2 * IMG_WIDTH / 8);
  logic       tp_q, tp1_q;
  logic [2:0] bar1_q;

  // The pattern selection is latched on frame_start but already governs that first cycle.
  assign tp_eff = frame_start ? test_pattern : tp_q;

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      tp_q   <= 1'b0;
      tp1_q  <= 1'b0;
      bar1_q <= '0;
    end else begin
      if (frame_start) tp_q <= test_pattern;
      tp1_q  <= tp_eff;
      bar1_q <= 3'(vga_x / BAR_W);
    end
  end
`else
  assign tp_eff = 1'b0;
`endif

  always_comb begin
    in_area = video_on && (vga_x < X_END) && (vga_y < Y_END);
    run     = !rst && (frame_start || state_q == ACTIVE);
    due     = run && in_area && !vga_y[0] && !vga_x[0] && !tp_eff;
    pop     = due && !fifo_empty;
    starve  = due && fifo_empty;
  end

  assign fifo_read_enable = pop;

  // Even lines show the word arriving from the FIFO, then its held copy; odd lines replay the line buffer.
  always_comb begin
    pix   = odd1_q ? rd_q : (xodd1_q ? hold_q : fifo_read_data);
    rgb_d = {pix[15:12], pix[10:7], pix[4:1]};
`ifdef VGA_SCALER_TESTPAT_EN
    if (tp1_q) rgb_d = {{4{~bar1_q[1]}}, {4{~bar1_q[2]}}, {4{~bar1_q[0]}}};
`endif
    if (!show1_q) rgb_d = '0;
  end

  assign unused_bits = ^{pix[11], pix[6:5], pix[0]};

  always_ff @(posedge clk_vga) begin
    if (run && in_area && vga_y[0]) rd_q <= linebuf[vga_x[AW:1]];
    if (wr1_q) linebuf[addr1_q] <= fifo_read_data;
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      state_q     <= IDLE;
      pop_count_q <= '0;
      underrun_q  <= 1'b0;
      show1_q     <= 1'b0;
      odd1_q      <= 1'b0;
      xodd1_q     <= 1'b0;
      wr1_q       <= 1'b0;
      addr1_q     <= '0;
      hs1_q       <= 1'b1;
      vs1_q       <= 1'b1;
      hs2_q       <= 1'b1;
      vs2_q       <= 1'b1;
      rgb_q       <= '0;
      hold_q      <= '0;
    end else begin
      if (frame_start) begin
        state_q     <= ACTIVE;
        pop_count_q <= pop ? 17'd1 : 17'd0;
      end else begin
        if (starve) state_q <= STARVED;
        if (pop && pop_count_q != FULL) pop_count_q <= pop_count_q + 17'd1;
      end
      if (starve) underrun_q <= 1'b1;
      show1_q <= run && in_area && !starve;
      odd1_q  <= vga_y[0];
      xodd1_q <= vga_x[0];
      wr1_q   <= pop;
      addr1_q <= vga_x[AW:1];
      hs1_q   <= hsync_in;
      vs1_q   <= vsync_in;
      hs2_q   <= hs1_q;
      vs2_q   <= vs1_q;
      rgb_q   <= rgb_d;
      if (wr1_q) hold_q <= fifo_read_data;
    end
  end

  assign {vga_r, vga_g, vga_b} = rgb_q;
  assign vga_hs    = hs2_q;
  assign vga_vs    = vs2_q;
  assign underrun  = underrun_q;
  assign pop_count = pop_count_q;

endmodule

// File: tb/tb_vga_pixel_scaler.sv
// Randomized bench for vga_pixel_scaler on a reduced 16x8 source image with a compressed VGA raster.
// Reference model derives each output pixel from the frame's FIFO snapshot and the display rules.
module tb_vga_pixel_scaler;

  localparam int W    = 16;
  localparam int H    = 8;
  localparam int AW   = 2 * W;
  localparam int AH   = 2 * H;
  localparam int HT   = AW + 8;
  localparam int VT   = AH + 3;
  localparam int FULL = W * H;
  localparam int BARW = AW / 8;
  localparam int M_IDLE = 0, M_ACT = 1, M_STARV = 2;
  localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                       12'hF0F, 12'hF00, 12'h00F, 12'h000};

  logic        clk = 1'b0;
  logic        rst, frame_start, video_on, hsync_in, vsync_in, fifo_empty, test_pattern;
  logic [9:0]  vga_x, vga_y;
  logic [15:0] fifo_read_data;
  logic        fifo_read_enable, vga_hs, vga_vs, underrun;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic [16:0] pop_count;

  always #5 clk = ~clk;

  vga_pixel_scaler #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(16)) dut (
    .clk_vga(clk), .rst(rst),
`ifdef VGA_SCALER_TESTPAT_EN
    .test_pattern(test_pattern),
`endif
    .frame_start(frame_start), .video_on(video_on), .vga_x(vga_x), .vga_y(vga_y),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .fifo_read_data(fifo_read_data),
    .fifo_empty(fifo_empty), .fifo_read_enable(fifo_read_enable),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .underrun(underrun), .pop_count(pop_count)
  );

  int          n_chk = 0, n_pass = 0;
  int          frame_no = 0, cur_x = 0, cur_y = 0;
  logic [15:0] q[$];
  logic [15:0] frm[$];
  logic [15:0] rdata = '0;
  int          nav = 0, mode = M_IDLE, pops = 0;
  bit          und = 1'b0, tp_mode = 1'b0;
  logic [11:0] c1 = '0, c2 = '0;
  logic        hs1 = 1'b1, hs2 = 1'b1, vs1 = 1'b1, vs2 = 1'b1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (frame %0d x=%0d y=%0d)",
                  tag, got, exp, frame_no, cur_x, cur_y);
  endtask

  function automatic logic [11:0] map565(input logic [15:0] w);
    return {w[15:12], w[10:7], w[4:1]};
  endfunction

  task automatic run_cycle(input int x, input int y, input bit fs, input bit rs, input bit tp);
    logic [11:0] col;
    bit          exp_ren, ren;
    int          k;
    cur_x = x; cur_y = y;
    if (x == 0 && y == 0) begin
      frm = q;
      nav = frm.size();
    end
    vga_x = 10'(x); vga_y = 10'(y);
    video_on = (x < AW) && (y < AH);
    frame_start = fs; rst = rs; test_pattern = tp;
    hsync_in = 1'($urandom); vsync_in = 1'($urandom);
    fifo_empty = (q.size() == 0);
    fifo_read_data = rdata;

    col = '0; exp_ren = 1'b0;
    if (rs) begin
      mode = M_IDLE; und = 1'b0; pops = 0;
    end else begin
      if (fs) begin
        mode = M_ACT; pops = 0;
`ifdef VGA_SCALER_TESTPAT_EN
        tp_mode = tp;
`else
        tp_mode = 1'b0;
`endif
      end
      if (mode == M_ACT && video_on) begin
        k = (y / 2) * W + x / 2;
        if (tp_mode) col = BARS[x / BARW];
        else if (y % 2 == 0 && x % 2 == 0) begin
          if (k < nav) begin
            exp_ren = 1'b1; pops++; col = map565(frm[k]);
          end else begin
            und = 1'b1;
            if (!fs) mode = M_STARV;
          end
        end else if (k < nav) col = map565(frm[k]);
      end
    end

    #1;
    ren = fifo_read_enable;
    if (!rs) check_eq("fifo_read_enable", int'(ren), int'(exp_ren));
    @(posedge clk);
    if (ren && q.size() > 0) rdata = q.pop_front();
    c2 = c1; c1 = col; hs2 = hs1; hs1 = hsync_in; vs2 = vs1; vs1 = vsync_in;
    if (rs) begin
      c1 = '0; c2 = '0; hs1 = 1'b1; hs2 = 1'b1; vs1 = 1'b1; vs2 = 1'b1;
    end
    #1;
    check_eq("rgb", int'({vga_r, vga_g, vga_b}), int'(c2));
    check_eq("vga_hs", int'(vga_hs), int'(hs2));
    check_eq("vga_vs", int'(vga_vs), int'(vs2));
    check_eq("underrun", int'(underrun), int'(und));
    check_eq("pop_count", int'(pop_count), (pops < FULL) ? pops : FULL);
  endtask

  task automatic run_frame(input bit fs, input int rst_y, input int rst_x, input bit tp);
    for (int y = 0; y < VT; y++)
      for (int x = 0; x < HT; x++)
        run_cycle(x, y, fs && x == 0 && y == 0, (y == rst_y && x == rst_x),
                  (x == 0 && y == 0) ? tp : 1'($urandom));
    frame_no++;
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) q.push_back(16'($urandom));
  endtask

  initial begin
    fill_random(FULL);
    for (int i = 0; i < 3; i++) run_cycle(AW + i, VT - 1, 1'b0, 1'b1, 1'b0);

    // idle until the first frame_start
    run_frame(1'b0, -1, 0, 1'b0);
    check_eq("idle_no_pops", q.size(), FULL);

    run_frame(1'b1, -1, 0, 1'b0);
    check_eq("pop_count_full", int'(pop_count), FULL);
    check_eq("underrun_clear", int'(underrun), 0);

    q.push_back(16'hF800);
    for (int i = 1; i < FULL; i++) q.push_back(16'h0000);
    run_frame(1'b1, -1, 0, 1'b0);

    fill_random(3 * W + 8);
    run_frame(1'b1, -1, 0, 1'b0);
    check_eq("starve_pops", int'(pop_count), 3 * W + 8);
    check_eq("underrun_set", int'(underrun), 1);

    fill_random(FULL);
    run_frame(1'b1, -1, 0, 1'b0);
    check_eq("underrun_sticky", int'(underrun), 1);

    // no frame_start: stays active, counter must saturate
    fill_random(FULL);
    run_frame(1'b0, -1, 0, 1'b0);
    check_eq("pop_count_sat", int'(pop_count), FULL);

    fill_random(FULL);
    run_frame(1'b1, 10, 7, 1'b0);
    check_eq("rst_pop_count", int'(pop_count), 0);
    check_eq("rst_underrun", int'(underrun), 0);

    while (q.size() < FULL) q.push_back(16'($urandom));
    run_frame(1'b1, -1, 0, 1'b0);
    check_eq("refill_pops", int'(pop_count), FULL);

`ifdef VGA_SCALER_TESTPAT_EN
    fill_random(5);
    run_frame(1'b1, -1, 0, 1'b1);
    check_eq("tp_no_pops", int'(pop_count), 0);
    check_eq("tp_underrun", int'(underrun), 0);
    while (q.size() < FULL) q.push_back(16'($urandom));
    run_frame(1'b1, -1, 0, 1'b0);
    check_eq("tp_off_pops", int'(pop_count), FULL);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
